// File: rtl/bridge_pkg.sv
// Shared types and defaults for the UART-to-core-bus bridge sequencer.
package bridge_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam int unsigned         TIMEOUT_DEFAULT      = 255;
    localparam logic [DATA_W-1:0]   TIMEOUT_DATA_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_READ = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    // Command entry: {rw, addr, data}, 33 bits.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO; a push is accepted when full if a pop happens in the same cycle.
module cmd_fifo
    import bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head_c,
    output logic full_c,
    output logic empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    // Storage array; no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bridge_sequencer.sv
// Sequences UART-decoded commands onto the core bus, one at a time, returning read results to the TX bridge.
module bridge_sequencer
    import bridge_pkg::*;
#(
    parameter int unsigned        DEPTH        = 4,
    parameter int unsigned        TIMEOUT      = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rx_addr_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_rw_i,
    input  logic              rx_valid_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_rw_o,
    output logic              bus_valid_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_rvalid_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              overflow_o,
    output logic              timeout_o
);

    // Expiry fires on the cycle the counter would step onto TIMEOUT-1.
    localparam logic [CNT_W:0] EXPIRE_AT = (CNT_W+1)'(TIMEOUT) - (CNT_W+1)'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              bus_rw_q, bus_rw_d;
    logic              bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q;

    cmd_t              rx_cmd_c;
    cmd_t              head_c;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              expire_c;

    assign rx_cmd_c = '{rw: rx_rw_i, addr: rx_addr_i, data: rx_data_i};
    assign push_c   = rx_valid_i && !rst;
    assign expire_c = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= EXPIRE_AT;

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (rx_cmd_c),
        .pop       (pop_c),
        .head_c    (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_rw_q    <= 1'b0;
            bus_valid_q <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_rw_q    <= bus_rw_d;
            bus_valid_q <= bus_valid_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Sticky drop flag: a command arrived with the FIFO full and no pop to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (rx_valid_i && full_c && !pop_c) begin
            overflow_q <= 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_addr_d  = '0;
        bus_data_d  = '0;
        bus_rw_d    = 1'b0;
        bus_valid_d = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        timeout_d   = 1'b0;
        pop_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d     = ST_ISSUE;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = head_c.addr;
                    bus_data_d  = head_c.data;
                    bus_rw_d    = head_c.rw;
                end
            end
            ST_ISSUE: begin
                pop_c   = 1'b1;
                cnt_d   = '0;
                state_d = bus_rw_q ? ST_IDLE : ST_WAIT_READ;
            end
            ST_WAIT_READ: begin
                if (bus_rvalid_i) begin
                    state_d    = ST_RESPOND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = bus_rdata_i;
                end else if (expire_c) begin
                    state_d    = ST_RESPOND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = TIMEOUT_DATA;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                if (tx_ready_i) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_addr_o  = bus_addr_q;
    assign bus_data_o  = bus_data_q;
    assign bus_rw_o    = bus_rw_q;
    assign bus_valid_o = bus_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed self-checking bench for bridge_sequencer (DEPTH 4, TIMEOUT 8).
module tb_bridge_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_addr_i;
    logic [15:0] rx_data_i;
    logic        rx_rw_i;
    logic        rx_valid_i;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic        bus_rw_o;
    logic        bus_valid_o;
    logic [15:0] bus_rdata_i;
    logic        bus_rvalid_i;
    logic [15:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        overflow_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    bridge_sequencer #(
        .DEPTH        (4),
        .TIMEOUT      (8),
        .TIMEOUT_DATA (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_addr_i    (rx_addr_i),
        .rx_data_i    (rx_data_i),
        .rx_rw_i      (rx_rw_i),
        .rx_valid_i   (rx_valid_i),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_rw_o     (bus_rw_o),
        .bus_valid_o  (bus_valid_o),
        .bus_rdata_i  (bus_rdata_i),
        .bus_rvalid_i (bus_rvalid_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .overflow_o   (overflow_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rx strobe; returns one cycle after the strobe.
    task automatic send(input logic rw, input logic [15:0] addr, input logic [15:0] data);
        rx_rw_i    = rw;
        rx_addr_i  = addr;
        rx_data_i  = data;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        rx_rw_i    = 1'b0;
        rx_addr_i  = '0;
        rx_data_i  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_valid"}, 32'(bus_valid_o), 32'h0);
        check({tag, "_bus_addr"},  32'(bus_addr_o),  32'h0);
        check({tag, "_bus_data"},  32'(bus_data_o),  32'h0);
        check({tag, "_bus_rw"},    32'(bus_rw_o),    32'h0);
        check({tag, "_tx_valid"},  32'(tx_valid_o),  32'h0);
        check({tag, "_tx_data"},   32'(tx_data_o),   32'h0);
        check({tag, "_overflow"},  32'(overflow_o),  32'h0);
        check({tag, "_timeout"},   32'(timeout_o),   32'h0);
    endtask

    task automatic check_issue(input string tag, input logic rw, input logic [15:0] addr,
                               input logic [15:0] data);
        check({tag, "_valid"}, 32'(bus_valid_o), 32'h1);
        check({tag, "_rw"},    32'(bus_rw_o),    32'(rw));
        check({tag, "_addr"},  32'(bus_addr_o),  32'(addr));
        check({tag, "_data"},  32'(bus_data_o),  32'(data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        rx_addr_i    = 16'hEEEE;
        rx_data_i    = 16'hEEEE;
        rx_rw_i      = 1'b1;
        rx_valid_i   = 1'b1;
        bus_rdata_i  = '0;
        bus_rvalid_i = 1'b0;
        tx_ready_i   = 1'b1;

        // Reset state; rx strobe held during reset must be ignored.
        tick();
        tick();
        check_all_zero("reset");
        rst        = 1'b0;
        rx_valid_i = 1'b0;
        rx_addr_i  = '0;
        rx_data_i  = '0;
        rx_rw_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rx_during_rst_ignored", 32'(bus_valid_o), 32'h0);
        end

        // Write: strobe at N, request at N+2, FIFO empty afterward.
        send(1'b1, 16'h1234, 16'hABCD);
        check("wr_n1_valid", 32'(bus_valid_o), 32'h0);
        tick();
        check_issue("wr", 1'b1, 16'h1234, 16'hABCD);
        tick();
        check("wr_after_valid", 32'(bus_valid_o), 32'h0);
        check("wr_after_addr",  32'(bus_addr_o),  32'h0);
        check("wr_after_data",  32'(bus_data_o),  32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_fifo_empty", 32'(bus_valid_o), 32'h0);
        end

        // Stray read response while idle is ignored.
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h1111;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("stray_rvalid_tx", 32'(tx_valid_o), 32'h0);
        tick();
        check("stray_rvalid_tx2", 32'(tx_valid_o), 32'h0);

        // Read answered three cycles after issue.
        send(1'b0, 16'h0010, 16'h0000);
        tick();
        check_issue("rd", 1'b0, 16'h0010, 16'h0000);
        tick();
        tick();
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h5A5A;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("rd_tx_valid", 32'(tx_valid_o), 32'h1);
        check("rd_tx_data",  32'(tx_data_o),  32'h5A5A);
        check("rd_timeout",  32'(timeout_o),  32'h0);
        tick();
        check("rd_tx_valid_drop", 32'(tx_valid_o), 32'h0);
        check("rd_tx_data_drop",  32'(tx_data_o),  32'h0);

        // Read timeout: response and pulse exactly 8 cycles after issue.
        send(1'b0, 16'h0020, 16'h0000);
        tick();
        check_issue("to", 1'b0, 16'h0020, 16'h0000);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("to_waiting", 32'(tx_valid_o), 32'h0);
        end
        tick();
        check("to_tx_valid", 32'(tx_valid_o), 32'h1);
        check("to_tx_data",  32'(tx_data_o),  32'h0000);
        check("to_pulse",    32'(timeout_o),  32'h1);
        tick();
        check("to_pulse_end", 32'(timeout_o),  32'h0);
        check("to_tx_end",    32'(tx_valid_o), 32'h0);

        // Response on the expiry cycle wins over the timeout.
        send(1'b0, 16'h0022, 16'h0000);
        tick();
        check_issue("race", 1'b0, 16'h0022, 16'h0000);
        repeat (7) tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h1111;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("race_tx_valid", 32'(tx_valid_o), 32'h1);
        check("race_tx_data",  32'(tx_data_o),  32'h1111);
        check("race_no_pulse", 32'(timeout_o),  32'h0);
        tick();
        check("race_tx_end", 32'(tx_valid_o), 32'h0);

        // Six strobes while stalled in WAIT_READ: four kept, overflow set, order preserved.
        send(1'b0, 16'h0030, 16'h0000);
        tick();
        check_issue("ovf_rd", 1'b0, 16'h0030, 16'h0000);
        tick();
        for (int k = 0; k < 6; k++) begin
            rx_rw_i    = 1'b1;
            rx_addr_i  = 16'h0100 + 16'(k);
            rx_data_i  = 16'hB000 + 16'(k);
            rx_valid_i = 1'b1;
            tick();
            check("ovf_flag", 32'(overflow_o), 32'(k >= 4));
        end
        rx_valid_i = 1'b0;
        rx_rw_i    = 1'b0;
        rx_addr_i  = '0;
        rx_data_i  = '0;
        tick();
        check("ovf_rd_timeout", 32'(timeout_o),  32'h1);
        check("ovf_rd_tx",      32'(tx_valid_o), 32'h1);
        tick();
        check("ovf_rd_tx_end", 32'(tx_valid_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_issue("ovf_wr", 1'b1, 16'h0100 + 16'(k), 16'hB000 + 16'(k));
            tick();
            check("ovf_wr_gap", 32'(bus_valid_o), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ovf_no_fifth", 32'(bus_valid_o), 32'h0);
        end
        check("ovf_sticky", 32'(overflow_o), 32'h1);

        // TX backpressure: data held stable and no new request until handshake.
        tx_ready_i = 1'b0;
        send(1'b0, 16'h0040, 16'h0000);
        tick();
        check_issue("bp_rd", 1'b0, 16'h0040, 16'h0000);
        tick();
        rx_rw_i    = 1'b1;
        rx_addr_i  = 16'h0050;
        rx_data_i  = 16'hDDDD;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        rx_rw_i    = 1'b0;
        rx_addr_i  = '0;
        rx_data_i  = '0;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h7E7E;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("bp_tx_valid", 32'(tx_valid_o), 32'h1);
        check("bp_tx_data",  32'(tx_data_o),  32'h7E7E);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 32'(tx_valid_o),  32'h1);
            check("bp_hold_data",  32'(tx_data_o),   32'h7E7E);
            check("bp_no_issue",   32'(bus_valid_o), 32'h0);
        end
        tx_ready_i = 1'b1;
        tick();
        check("bp_tx_done", 32'(tx_valid_o), 32'h0);
        check("bp_tx_zero", 32'(tx_data_o),  32'h0);
        tick();
        check_issue("bp_wr", 1'b1, 16'h0050, 16'hDDDD);
        tick();
        check("bp_wr_end", 32'(bus_valid_o), 32'h0);

        // Reset mid-read; a late response is ignored; overflow cleared.
        send(1'b0, 16'h0060, 16'h0000);
        tick();
        check_issue("rst_rd", 1'b0, 16'h0060, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_midread");
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h9999;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("late_rvalid_tx",  32'(tx_valid_o),  32'h0);
            check("late_rvalid_bus", 32'(bus_valid_o), 32'h0);
        end
        send(1'b1, 16'h0070, 16'h1357);
        tick();
        check_issue("post_rst_wr", 1'b1, 16'h0070, 16'h1357);
        tick();

        // Reset mid-handshake drops tx_valid.
        tx_ready_i = 1'b0;
        send(1'b0, 16'h0080, 16'h0000);
        tick();
        check_issue("rst_hs_rd", 1'b0, 16'h0080, 16'h0000);
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 16'h2468;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("rst_hs_tx_valid", 32'(tx_valid_o), 32'h1);
        check("rst_hs_tx_data",  32'(tx_data_o),  32'h2468);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_midhs");
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hs_quiet", 32'(tx_valid_o), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
